// File: rtl/mouse_master_sm_if.sv
// PS/2 host link between the mouse sequencer and its transmitter/receiver.
// master: sequencer side (drives SEND_BYTE/BYTE_TO_SEND/READ_ENABLE).
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output SEND_BYTE,
    output BYTE_TO_SEND,
    output READ_ENABLE,
    input  BYTE_SENT,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  modport slave (
    input  SEND_BYTE,
    input  BYTE_TO_SEND,
    input  READ_ENABLE,
    output BYTE_SENT,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY
  );
endinterface

// File: rtl/mouse_master_sm.sv
// PS/2 mouse host sequencer: reset/enable handshake, 3-byte packet framing.
// Ports: CLK/RESET, link (tx/rx handshake), MOUSE_* packet regs, IRQ, INIT_DONE.
module mouse_master_sm #(
  parameter int INIT_DELAY   = 5000000,
  parameter int RESP_TIMEOUT = 50000000,
  parameter int PKT_TIMEOUT  = 200000,
  parameter int CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  mouse_master_sm_if.master link,
  output logic [7:0]        MOUSE_STATUS,
  output logic [7:0]        MOUSE_DX,
  output logic [7:0]        MOUSE_DY,
  output logic              SEND_INTERRUPT,
  output logic              INIT_DONE
);

  typedef enum logic [3:0] {
    INIT_WAIT,
    SEND_RST,
    WAIT_RST_SENT,
    ACK_RST,
    SELFTEST,
    ID,
    SEND_EN,
    WAIT_EN_SENT,
    ACK_EN,
    STREAM_S,
    STREAM_X,
    STREAM_Y
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LAST =
    CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] RESP_LAST =
    CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PKT_LAST =
    CNT_W'(PKT_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;

  logic [7:0] shadow_s;
  logic [7:0] shadow_x;
  logic       irq_q;

  logic rdy;
  logic good;
  logic resp_to;
  logic pkt_to;
  logic cap_s;
  logic cap_x;
  logic load;
  logic read_en;
  logic stream;

  assign rdy     = link.BYTE_READY;
  assign good    = rdy && (link.BYTE_ERROR_CODE == 2'b00);
  assign resp_to = (timer == RESP_LAST);
  assign pkt_to  = (timer == PKT_LAST);

  // State register and shared timer; timer restarts on every transition
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= INIT_WAIT;
      timer <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
    end
  end

  // Next state; an arriving byte/done always outranks a timeout
  always_comb begin
    next_state = state;
    unique case (state)
      INIT_WAIT:
        if (timer == INIT_LAST) next_state = SEND_RST;
      SEND_RST:
        next_state = WAIT_RST_SENT;
      WAIT_RST_SENT:
        if (link.BYTE_SENT) next_state = ACK_RST;
        else if (resp_to)   next_state = INIT_WAIT;
      ACK_RST:
        if (rdy)
          next_state = (good && link.BYTE_READ == 8'hFA)
                       ? SELFTEST : INIT_WAIT;
        else if (resp_to) next_state = INIT_WAIT;
      SELFTEST:
        if (rdy)
          next_state = (good && link.BYTE_READ == 8'hAA)
                       ? ID : INIT_WAIT;
        else if (resp_to) next_state = INIT_WAIT;
      ID:
        if (rdy)
          next_state = (good && link.BYTE_READ == 8'h00)
                       ? SEND_EN : INIT_WAIT;
        else if (resp_to) next_state = INIT_WAIT;
      SEND_EN:
        next_state = WAIT_EN_SENT;
      WAIT_EN_SENT:
        if (link.BYTE_SENT) next_state = ACK_EN;
        else if (resp_to)   next_state = INIT_WAIT;
      ACK_EN:
        if (rdy)
          next_state = (good && link.BYTE_READ == 8'hFA)
                       ? STREAM_S : INIT_WAIT;
        else if (resp_to) next_state = INIT_WAIT;
      STREAM_S:
        // bit3 is always set in a status byte; use it to resync
        if (good && link.BYTE_READ[3]) next_state = STREAM_X;
      STREAM_X:
        if (rdy)         next_state = good ? STREAM_Y : STREAM_S;
        else if (pkt_to) next_state = STREAM_S;
      STREAM_Y:
        if (rdy)         next_state = STREAM_S;
        else if (pkt_to) next_state = STREAM_S;
      default:
        next_state = INIT_WAIT;
    endcase
  end

  // Moore-style controls and datapath strobes
  always_comb begin
    read_en = 1'b0;
    stream  = 1'b0;
    cap_s   = 1'b0;
    cap_x   = 1'b0;
    load    = 1'b0;
    unique case (state)
      ACK_RST, SELFTEST, ID, ACK_EN:
        read_en = 1'b1;
      STREAM_S: begin
        read_en = 1'b1;
        stream  = 1'b1;
        cap_s   = good && link.BYTE_READ[3];
      end
      STREAM_X: begin
        read_en = 1'b1;
        stream  = 1'b1;
        cap_x   = good;
      end
      STREAM_Y: begin
        read_en = 1'b1;
        stream  = 1'b1;
        load    = good;
      end
      default: ;
    endcase
  end

  assign link.READ_ENABLE = read_en;
  assign INIT_DONE        = stream;

  // Command issue, packet shadowing and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      link.SEND_BYTE    <= 1'b0;
      link.BYTE_TO_SEND <= 8'h00;
      shadow_s          <= 8'h00;
      shadow_x          <= 8'h00;
      MOUSE_STATUS      <= 8'h00;
      MOUSE_DX          <= 8'h00;
      MOUSE_DY          <= 8'h00;
      irq_q             <= 1'b0;
      SEND_INTERRUPT    <= 1'b0;
    end else begin
      link.SEND_BYTE <= (state == SEND_RST) ||
                        (state == SEND_EN);
      // command byte stays put until the next command
      if (state == SEND_RST)
        link.BYTE_TO_SEND <= 8'hFF;
      else if (state == SEND_EN)
        link.BYTE_TO_SEND <= 8'hF4;
      if (cap_s) shadow_s <= link.BYTE_READ;
      if (cap_x) shadow_x <= link.BYTE_READ;
      if (load) begin
        MOUSE_STATUS <= shadow_s;
        MOUSE_DX     <= shadow_x;
        MOUSE_DY     <= link.BYTE_READ;
      end
      irq_q          <= load;
      SEND_INTERRUPT <= irq_q;
    end
  end

endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
Host-side sequencer for the PS/2 mouse link. It drives the MouseTransmitter SEND_BYTE/BYTE_TO_SEND handshake and consumes bytes from the mouse receiver. It performs the power-up handshake: reset FF, expect FA/AA/00; enable reporting F4, expect FA. It then frames 3-byte stream packets into status/dX/dY registers, pulses an interrupt per packet, and restarts initialisation on any protocol failure or timeout.

Parameters:
INIT_DELAY, 5000000, CLK cycles idled after reset before the first command (50 ms at 100 MHz)
RESP_TIMEOUT, 50000000, max CLK cycles spent in any init wait state before restart
PKT_TIMEOUT, 200000, max CLK cycles between bytes of one stream packet before resync
CNT_W, 32, width of the shared timer; must hold the largest of the three limits

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous active-high reset
SEND_BYTE  output  1  one-cycle request to transmitter
BYTE_TO_SEND  output  8  command byte, valid while SEND_BYTE=1 and held until BYTE_SENT
BYTE_SENT  input  1  transmitter done pulse
READ_ENABLE  output  1  receiver enable
BYTE_READ  input  8  received byte
BYTE_ERROR_CODE  input  2  receiver error: 00 ok, bit0 parity, bit1 stop
BYTE_READY  input  1  one-cycle received-byte strobe
MOUSE_STATUS  output  8  last valid packet byte 0
MOUSE_DX  output  8  last valid packet byte 1
MOUSE_DY  output  8  last valid packet byte 2
SEND_INTERRUPT  output  1  one-cycle pulse when all three outputs update
INIT_DONE  output  1  high while in stream states

Behaviour:
- Reset (sync, on CLK edge with RESET=1): state=INIT_WAIT, timer=0. All outputs are 0, including BYTE_TO_SEND=00. Reset mid-transfer aborts immediately; no pending SEND_BYTE is issued.
- Timer: cleared on every state change. Increments otherwise. Saturates at all-ones.
- INIT_WAIT: READ_ENABLE=0. When timer==INIT_DELAY-1, go to SEND_RST.
- SEND_RST: SEND_BYTE=1 and BYTE_TO_SEND=FF for exactly one cycle, then go to WAIT_RST_SENT.
- WAIT_RST_SENT: on BYTE_SENT, go to ACK_RST.
- ACK_RST, SELFTEST, ID: READ_ENABLE=1. On BYTE_READY, check the byte against the expected value: FA, AA and 00 respectively, with error code 00.
  - Match: advance to the next state. ID advances to SEND_EN.
  - Mismatch or nonzero error code: go to INIT_WAIT.
- SEND_EN: same as SEND_RST with byte F4. Then WAIT_EN_SENT (exit on BYTE_SENT), then ACK_EN (expects FA, same rules). Match goes to STREAM_S.
- Timeout: in every init state except INIT_WAIT, timer reaching RESP_TIMEOUT-1 goes to INIT_WAIT.
- Stream (INIT_DONE=1, READ_ENABLE=1): STREAM_S, STREAM_X, STREAM_Y.
  - STREAM_S: on a good byte with bit3=1, capture it into a shadow register and go to STREAM_X. A byte with bit3=0 or an error is discarded; stay in STREAM_S.
  - STREAM_X: capture a good byte into shadow, go to STREAM_Y.
  - STREAM_Y: on a good byte, load MOUSE_STATUS/DX/DY from shadow plus the current byte in the same cycle. Pulse SEND_INTERRUPT the following cycle. Return to STREAM_S.
  - An error byte in STREAM_X or STREAM_Y drops the packet and returns to STREAM_S; outputs are unchanged.
  - PKT_TIMEOUT expiring in STREAM_X or STREAM_Y returns to STREAM_S. No timeout applies in STREAM_S.
- Output registers change only on a complete packet and otherwise hold their last values.
- BYTE_SENT or BYTE_READY arriving in a state that does not expect it is ignored.
- BYTE_READY coincident with timeout expiry: the byte wins; the state is evaluated as if no timeout occurred.
- Latency: SEND_BYTE is asserted 1 cycle after entering SEND_RST/SEND_EN. Outputs update 0 cycles after the final BYTE_READY edge; the interrupt follows 1 cycle later.

Test Plan:
- Clean init: INIT_DELAY=100, RESP_TIMEOUT=1000; model returns BYTE_SENT and FA,AA,00 then FA. Required: SEND_BYTE with FF at cycle ~101, then with F4; INIT_DONE=1 after the final FA; exactly 2 SEND_BYTE pulses.
- Bad self-test: reply FA then FC. Required: return to INIT_WAIT; FF is re-sent after 100 cycles; INIT_DONE stays 0.
- Timeout: no BYTE_SENT after FF. Required: after 1000 cycles state returns to INIT_WAIT and FF is retransmitted.
- Packet: in stream, send 09, 05, FB. Required: MOUSE_STATUS=09, DX=05, DY=FB; one SEND_INTERRUPT pulse.
- Resync: send 00 (bit3=0), then 08,01,02; separately send 08,01 and stall beyond PKT_TIMEOUT then 0A,03,04. Required: first case yields 08/01/02. Second case yields 0A/03/04 with no interrupt for the stalled packet.
- Parity error in STREAM_Y and RESET asserted mid-packet: outputs hold the previous packet on the error. RESET clears all outputs next edge and restarts INIT_WAIT.
